// File: rtl/student_iis_fir_scheduler.sv
// Moves codec samples one at a time from the IIS receiver through the FIR core to the IIS transmitter.
// A small FIFO absorbs FIR jitter; a watchdog bounds each FIR wait; bypass forwards samples sign-extended.
module student_iis_fir_scheduler #(
  parameter int DATA_SIZE         = 16,
  parameter int DATA_SIZE_FIR_OUT = 32,
  parameter int FIFO_DEPTH        = 4,
  parameter int TIMEOUT_CYCLES    = 1000
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         enable_i,
  input  logic                         bypass_i,
  input  logic                         clear_i,
  input  logic [DATA_SIZE-1:0]         rx_data_i,
  input  logic                         rx_valid_i,
  output logic [DATA_SIZE-1:0]         fir_data_o,
  output logic                         fir_valid_o,
  input  logic                         fir_ready_i,
  input  logic [DATA_SIZE_FIR_OUT-1:0] fir_result_i,
  input  logic                         fir_done_i,
  output logic [DATA_SIZE_FIR_OUT-1:0] tx_data_o,
  output logic                         tx_valid_o,
  output logic                         busy_o,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level_o,
  output logic [15:0]                  overrun_cnt_o,
  output logic [15:0]                  timeout_cnt_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, EMIT} state_t;

  state_t                         state_reg, state_next;
  logic [DATA_SIZE-1:0]           mem_reg [FIFO_DEPTH];
  logic [AW-1:0]                  wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]                  level_reg;
  logic [9:0]                     watchdog_reg;
  logic [DATA_SIZE_FIR_OUT-1:0]   tx_data_reg, tx_load_val;
  logic [15:0]                    overrun_reg, timeout_reg;

  logic                 push_req, push_ok, overrun_hit, pop, full, empty;
  logic                 tx_load, wd_clear, timeout_hit;
  logic [DATA_SIZE-1:0] head;

  assign head        = mem_reg[rd_ptr_reg];
  assign full        = (level_reg == LW'(FIFO_DEPTH));
  assign empty       = (level_reg == '0);
  assign push_req    = rx_valid_i & enable_i;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok     = push_req & (~full | pop);
  assign overrun_hit = push_req & full & ~pop;

  always_comb begin
    state_next  = state_reg;
    pop         = 1'b0;
    tx_load     = 1'b0;
    tx_load_val = '0;
    wd_clear    = 1'b0;
    timeout_hit = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!empty && enable_i) begin
          if (bypass_i) begin
            pop         = 1'b1;
            tx_load     = 1'b1;
            tx_load_val = DATA_SIZE_FIR_OUT'($signed(head));
            state_next  = EMIT;
          end else begin
            state_next  = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (fir_ready_i) begin
          pop        = 1'b1;
          wd_clear   = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        // A done on the expiry cycle still delivers the real result.
        if (fir_done_i) begin
          tx_load     = 1'b1;
          tx_load_val = fir_result_i;
          state_next  = EMIT;
        end else if (watchdog_reg == 10'(TIMEOUT_CYCLES - 1)) begin
          tx_load     = 1'b1;
          timeout_hit = 1'b1;
          state_next  = EMIT;
        end
      end
      EMIT:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      watchdog_reg <= '0;
      tx_data_reg  <= '0;
      overrun_reg  <= '0;
      timeout_reg  <= '0;
    end else if (clear_i) begin
      state_reg    <= IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      watchdog_reg <= '0;
      overrun_reg  <= '0;
      timeout_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      level_reg  <= level_reg + LW'(push_ok) - LW'(pop);
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (wd_clear)
        watchdog_reg <= '0;
      else if (state_reg == WAIT)
        watchdog_reg <= watchdog_reg + 1'b1;
      if (tx_load) tx_data_reg <= tx_load_val;
      if (overrun_hit && overrun_reg != 16'hFFFF) overrun_reg <= overrun_reg + 1'b1;
      if (timeout_hit && timeout_reg != 16'hFFFF) timeout_reg <= timeout_reg + 1'b1;
    end
  end

  // Sample storage carries no reset; occupancy is tracked by level_reg.
  always_ff @(posedge clk_i) begin
    if (push_ok && !clear_i) mem_reg[wr_ptr_reg] <= rx_data_i;
  end

  assign fir_valid_o   = (state_reg == ISSUE);
  assign fir_data_o    = (state_reg == ISSUE) ? head : '0;
  assign tx_valid_o    = (state_reg == EMIT);
  assign tx_data_o     = tx_data_reg;
  assign busy_o        = (state_reg != IDLE);
  assign fifo_level_o  = level_reg;
  assign overrun_cnt_o = overrun_reg;
  assign timeout_cnt_o = timeout_reg;

endmodule

// File: tb/tb_student_iis_fir_scheduler.sv
// Directed bench for student_iis_fir_scheduler: a queue-based transaction model checked every cycle,
// plus literal expectations at the cycles the timing rules pin down.
module tb_student_iis_fir_scheduler;
  localparam int DEPTH = 4;
  localparam int TO    = 20;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        en = 1'b0, byp = 1'b0, clr = 1'b0;
  logic [15:0] rx_data = '0;
  logic        rx_valid = 1'b0, fir_ready = 1'b0, fir_done = 1'b0;
  logic [31:0] fir_result = '0;
  logic [15:0] fir_data;
  logic        fir_valid, tx_valid, busy;
  logic [31:0] tx_data;
  logic [2:0]  level;
  logic [15:0] ovr_cnt, to_cnt;

  always #5 clk = ~clk;

  student_iis_fir_scheduler #(
    .DATA_SIZE(16), .DATA_SIZE_FIR_OUT(32), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .bypass_i(byp), .clear_i(clr),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .fir_data_o(fir_data), .fir_valid_o(fir_valid), .fir_ready_i(fir_ready),
    .fir_result_i(fir_result), .fir_done_i(fir_done),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .busy_o(busy),
    .fifo_level_o(level), .overrun_cnt_o(ovr_cnt), .timeout_cnt_o(to_cnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: pending samples in a queue, one transaction in flight at a time.
  logic [15:0] m_q[$];
  bit          m_offered = 0, m_waiting = 0, m_emitting = 0;
  int          m_waited = 0;
  logic [31:0] m_tx = '0;
  logic [15:0] m_ovr = '0, m_to = '0;

  initial begin : model
    bit was_full, took, busy_now;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_q.delete(); m_offered = 0; m_waiting = 0; m_emitting = 0; m_waited = 0;
        m_tx = '0; m_ovr = '0; m_to = '0;
      end else if (clr) begin
        m_q.delete(); m_offered = 0; m_waiting = 0; m_emitting = 0; m_waited = 0;
        m_ovr = '0; m_to = '0;
      end else begin
        was_full = (m_q.size() == DEPTH);
        took     = 0;
        busy_now = m_offered | m_waiting | m_emitting;
        if (m_emitting) begin
          m_emitting = 0;
        end else if (m_waiting) begin
          if (fir_done) begin
            m_tx = fir_result; m_waiting = 0; m_emitting = 1;
          end else if (m_waited + 1 == TO) begin
            m_tx = '0; m_waiting = 0; m_emitting = 1;
            if (m_to != 16'hFFFF) m_to++;
          end else begin
            m_waited++;
          end
        end else if (m_offered) begin
          if (fir_ready) begin
            void'(m_q.pop_front()); took = 1; m_offered = 0; m_waiting = 1; m_waited = 0;
          end
        end else if (!busy_now && m_q.size() > 0 && en) begin
          if (byp) begin
            m_tx = 32'($signed(m_q.pop_front())); took = 1; m_emitting = 1;
          end else begin
            m_offered = 1;
          end
        end
        if (rx_valid && en) begin
          if (!was_full || took) m_q.push_back(rx_data);
          else if (m_ovr != 16'hFFFF) m_ovr++;
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      check("cyc_fir_valid", 32'(fir_valid), 32'(m_offered));
      check("cyc_fir_data", 32'(fir_data), m_offered ? 32'(m_q[0]) : 32'h0);
      check("cyc_tx_valid", 32'(tx_valid), 32'(m_emitting));
      check("cyc_tx_data", tx_data, m_tx);
      check("cyc_busy", 32'(busy), 32'(m_offered | m_waiting | m_emitting));
      check("cyc_level", 32'(level), 32'(m_q.size()));
      check("cyc_overrun", 32'(ovr_cnt), 32'(m_ovr));
      check("cyc_timeout", 32'(to_cnt), 32'(m_to));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    rx_data = d; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_offer();
    int n;
    n = 0;
    while (!fir_valid && n < 50) begin
      tick();
      n++;
    end
    check("offer_within_budget", 32'(fir_valid), 32'h1);
  endtask

  task automatic finish_txn(input logic [31:0] r);
    fir_result = r; fir_done = 1'b1;
    tick();
    fir_done = 1'b0;
    check("done_tx_valid", 32'(tx_valid), 32'h1);
    check("done_tx_data", tx_data, r);
  endtask

  task automatic serve(input logic [15:0] d, input logic [31:0] r);
    wait_offer();
    check("serve_fir_data", 32'(fir_data), 32'(d));
    tick();
    finish_txn(r);
  endtask

  initial begin : stim
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_level", 32'(level), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_tx_data", tx_data, 32'h0);
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    en = 1'b1;

    // Single sample through the FIR.
    fir_ready = 1'b1;
    push(16'h1234);
    check("single_level_n1", 32'(level), 32'h1);
    check("single_valid_n1", 32'(fir_valid), 32'h0);
    tick();
    check("single_valid_n2", 32'(fir_valid), 32'h1);
    check("single_data_n2", 32'(fir_data), 32'h1234);
    tick();
    check("single_wait_valid", 32'(fir_valid), 32'h0);
    check("single_wait_level", 32'(level), 32'h0);
    repeat (9) tick();
    finish_txn(32'h0000_5678);
    tick();
    check("single_tx_pulse_end", 32'(tx_valid), 32'h0);

    // Overrun with the FIR stalled, then push and handshake in the same cycle on a full FIFO.
    fir_ready = 1'b0;
    for (int k = 1; k <= 6; k++) push(16'(k));
    check("ovr_level", 32'(level), 32'h4);
    check("ovr_count", 32'(ovr_cnt), 32'h2);
    check("ovr_head", 32'(fir_data), 32'h1);
    rx_data = 16'h0007; rx_valid = 1'b1; fir_ready = 1'b1;
    tick();
    rx_valid = 1'b0;
    check("simul_level", 32'(level), 32'h4);
    check("simul_overrun", 32'(ovr_cnt), 32'h2);
    finish_txn(32'h0000_0101);
    serve(16'h0002, 32'h0000_0102);
    serve(16'h0003, 32'h0000_0103);
    serve(16'h0004, 32'h0000_0104);
    serve(16'h0007, 32'h0000_0107);

    // Watchdog expiry: result 0 exactly TO+1 cycles after the handshake cycle.
    push(16'h00AA);
    wait_offer();
    tick();
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      check("to_early_tx_valid", 32'(tx_valid), 32'h0);
    end
    tick();
    check("to_tx_valid", 32'(tx_valid), 32'h1);
    check("to_tx_data", tx_data, 32'h0);
    check("to_count", 32'(to_cnt), 32'h1);

    // Done on the expiry cycle: result wins, no timeout counted.
    push(16'h00BB);
    wait_offer();
    tick();
    repeat (TO - 1) tick();
    finish_txn(32'hCAFE_0001);
    check("edge_to_count", 32'(to_cnt), 32'h1);

    // Bypass with sign extension.
    tick();
    byp = 1'b1;
    push(16'h8001);
    check("byp_fir_valid_n1", 32'(fir_valid), 32'h0);
    tick();
    check("byp_tx_valid", 32'(tx_valid), 32'h1);
    check("byp_tx_data", tx_data, 32'hFFFF_8001);
    check("byp_fir_valid_n2", 32'(fir_valid), 32'h0);
    tick();
    byp = 1'b0;

    // Clear during WAIT, then a late done.
    push(16'h00CC);
    wait_offer();
    tick();
    repeat (3) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_busy", 32'(busy), 32'h0);
    check("clr_level", 32'(level), 32'h0);
    check("clr_overrun", 32'(ovr_cnt), 32'h0);
    check("clr_timeout", 32'(to_cnt), 32'h0);
    check("clr_tx_hold", tx_data, 32'hFFFF_8001);
    fir_result = 32'hDEAD_BEEF; fir_done = 1'b1;
    tick();
    fir_done = 1'b0;
    check("clr_late_done", 32'(tx_valid), 32'h0);
    check("clr_late_busy", 32'(busy), 32'h0);

    // Asynchronous reset during WAIT, then a late done.
    push(16'h00DD);
    wait_offer();
    tick();
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    check("arst_tx_data", tx_data, 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_fir_valid", 32'(fir_valid), 32'h0);
    check("arst_level", 32'(level), 32'h0);
    tick();
    rst_n = 1'b1;
    fir_done = 1'b1;
    tick();
    fir_done = 1'b0;
    check("arst_late_done", 32'(tx_valid), 32'h0);
    check("arst_late_busy", 32'(busy), 32'h0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
